// File: rtl/aes128_dec_iter_pkg.sv
// Shared types and GF(2^8) / AES helper functions for the iterative AES-128 decryption core.
// S-boxes are derived from the field inverse plus affine map, not from lookup tables.
package aes128_dec_iter_pkg;

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;

  localparam logic [RND_W-1:0] LAST_RND  = 4'd10;
  localparam logic [RND_W-1:0] FIRST_DEC = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEXP  = 2'd1,
    ROUND = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 by square-and-multiply; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [WORD_W-1:0] inv_mix_col(input logic [WORD_W-1:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // SubWord(RotWord(w)) with the round constant folded into the top byte
  function automatic logic [WORD_W-1:0] key_core(input logic [WORD_W-1:0] w,
                                                 input logic [RND_W-1:0] idx);
    return {sbox(w[23:16]) ^ rcon(idx), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [BLK_W-1:0] next_key(input logic [BLK_W-1:0] k,
                                                input logic [RND_W-1:0] idx);
    logic [WORD_W-1:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ key_core(k[31:0], idx);
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // byte 0 sits in the MSBs of the block
  function automatic logic [7:0] get_byte(input logic [BLK_W-1:0] blk, input int idx);
    return 8'(blk >> (8 * (15 - idx)));
  endfunction

endpackage

// File: rtl/aes128_dec_iter_inv_round.sv
// One inverse AES round plus one step back through the key schedule, purely combinational.
module aes128_dec_iter_inv_round
  import aes128_dec_iter_pkg::*;
(
  input  logic [BLK_W-1:0] st_i,
  input  logic [BLK_W-1:0] key_i,
  input  logic [RND_W-1:0] rnd_i,
  output logic [BLK_W-1:0] next_st_o,
  output logic [BLK_W-1:0] prev_key_o,
  output logic [BLK_W-1:0] t_o
);

  logic [WORD_W-1:0] w0p, w1p, w2p, w3p;
  logic [BLK_W-1:0]  isr_sb;

  // key_i is round key rnd+1; walk it back to round key rnd
  always_comb begin
    w3p = key_i[31:0] ^ key_i[63:32];
    w2p = key_i[63:32] ^ key_i[95:64];
    w1p = key_i[95:64] ^ key_i[127:96];
    w0p = key_i[127:96] ^ key_core(w3p, rnd_i + 4'd1);
  end

  assign prev_key_o = {w0p, w1p, w2p, w3p};

  // InvShiftRows: row r of column c takes row r of column (c - r) mod 4
  always_comb begin
    isr_sb = '0;
    for (int i = 0; i < 16; i++) begin
      isr_sb = {isr_sb[BLK_W-9:0],
                inv_sbox(get_byte(st_i, 4 * (((i / 4) + 4 - (i % 4)) % 4) + (i % 4)))};
    end
  end

  assign t_o       = isr_sb ^ prev_key_o;
  assign next_st_o = {inv_mix_col(t_o[127:96]), inv_mix_col(t_o[95:64]),
                      inv_mix_col(t_o[63:32]),  inv_mix_col(t_o[31:0])};

endmodule

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys regenerated backwards
// from round key 10 so no key schedule is stored.
module aes128_dec_iter
  import aes128_dec_iter_pkg::*;
#(
  parameter bit LAST_KEY_IN = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [BLK_W-1:0] DIN,
  input  logic [BLK_W-1:0] KEY,
  output logic             BUSY,
  output logic             DONE,
  output logic [BLK_W-1:0] DOUT
);

  state_e           state_q;
  logic [RND_W-1:0] rnd_q;
  logic [BLK_W-1:0] ct_q, key_q, st_q, dout_q;
  logic             done_q, busy_q;

  logic [BLK_W-1:0] key_d, rnd_st_d, rnd_key_d, rnd_t;

  assign key_d = next_key(key_q, rnd_q);

  aes128_dec_iter_inv_round u_inv_round (
    .st_i       (st_q),
    .key_i      (key_q),
    .rnd_i      (rnd_q),
    .next_st_o  (rnd_st_d),
    .prev_key_o (rnd_key_d),
    .t_o        (rnd_t)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      ct_q    <= '0;
      key_q   <= '0;
      st_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            ct_q   <= DIN;
            key_q  <= KEY;
            busy_q <= 1'b1;
            if (LAST_KEY_IN) begin
              st_q    <= DIN ^ KEY;
              rnd_q   <= FIRST_DEC;
              state_q <= ROUND;
            end else begin
              rnd_q   <= 4'd1;
              state_q <= KEXP;
            end
          end
        end
        KEXP: begin
          if (rnd_q == 4'd0 || rnd_q > LAST_RND) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            key_q <= key_d;
            if (rnd_q == LAST_RND) begin
              st_q    <= ct_q ^ key_d;
              rnd_q   <= FIRST_DEC;
              state_q <= ROUND;
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end
        end
        ROUND: begin
          if (rnd_q > FIRST_DEC) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (rnd_q == 4'd0) begin
            dout_q  <= rnd_t;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            st_q  <= rnd_st_d;
            key_q <= rnd_key_d;
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign DOUT = dout_q;

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Bench for aes128_dec_iter: known-answer table, multi-cycle corner sequences and a
// loopback against an independent AES-128 encryption model, with a DONE-driven scoreboard.
module tb_aes128_dec_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start1;
  logic [127:0] din0, din1, key0, key1;
  logic         busy0, busy1, done0, done1;
  logic [127:0] dout0, dout1;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [7:0]   sb[256];

  always #5 clk = ~clk;

  aes128_dec_iter #(.LAST_KEY_IN(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .START(start0), .DIN(din0), .KEY(key0),
    .BUSY(busy0), .DONE(done0), .DOUT(dout0)
  );

  aes128_dec_iter #(.LAST_KEY_IN(1'b1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .DIN(din1), .KEY(key1),
    .BUSY(busy1), .DONE(done1), .DOUT(dout1)
  );

  typedef struct {
    bit           lki;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] pt;
    int           lat;
    int           busy;
  } vec_t;

  vec_t vt[3];

  // ---------------- reference encryption model ----------------
  function automatic logic [7:0] m_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = m_xt(x);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] m_kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    t  = k[31:0];
    w0 = k[127:96] ^ {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] m_key10(input logic [127:0] k);
    logic [127:0] rk;
    logic [7:0]   rc;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = m_kexp(rk, rc);
      rc = m_xt(rc);
    end
    return rk;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3, rc;
    logic [127:0] rk, out;
    rk = k;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ rk[127 - 8 * i -: 8];
    for (int r = 1; r <= 10; r++) begin
      rk = m_kexp(rk, rc);
      rc = m_xt(rc);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4 * c + w] = sb[s[4 * ((c + w) % 4) + w]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
        if (r < 10) begin
          s[4 * c]     = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
          s[4 * c + 3] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
        end else begin
          s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8 * i -: 8];
    end
    for (int i = 0; i < 16; i++) out[127 - 8 * i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- scoreboard: pop one expectation per DONE pulse ----------------
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst && done0) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL dut0_unexpected_done dout=%h", dout0);
      end else begin
        e = q0.pop_front();
        if (dout0 !== e) begin
          n_err++;
          $display("FAIL dut0_dout got=%h exp=%h", dout0, e);
        end
      end
    end
    if (!rst && done1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL dut1_unexpected_done dout=%h", dout1);
      end else begin
        e = q1.pop_front();
        if (dout1 !== e) begin
          n_err++;
          $display("FAIL dut1_dout got=%h exp=%h", dout1, e);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [127:0] k, input logic [127:0] d,
                       input logic [127:0] exp, input bit push);
    if (sel) begin
      start1 = 1'b1; din1 = d; key1 = k;
      if (push) q1.push_back(exp);
    end else begin
      start0 = 1'b1; din0 = d; key0 = k;
      if (push) q0.push_back(exp);
    end
  endtask

  // lat counts rising edges from (and including) the one that samples START
  task automatic wait_done(input bit sel, input int ign_at, input logic [127:0] ign_din,
                           output int lat, output int bcnt);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      start0 = 1'b0;
      start1 = 1'b0;
      if (lat == ign_at) begin
        if (sel) begin start1 = 1'b1; din1 = ign_din; end
        else     begin start0 = 1'b1; din0 = ign_din; end
      end
      if (sel ? done1 : done0) seen = 1'b1;
      else if (sel ? busy1 : busy0) bcnt++;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout sel=%0d", sel);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           lat, bcnt, dcnt;
    logic [127:0] k, p;

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    din0 = '0; din1 = '0; key0 = '0; key1 = '0;
    build_sbox();

    vt[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 21, 20};
    vt[1] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 21, 20};
    vt[2] = '{1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 11, 10};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", 128'(busy0), 128'd0);
    chk("rst_done0", 128'(done0), 128'd0);
    chk("rst_dout0", dout0, 128'd0);
    chk("rst_busy1", 128'(busy1), 128'd0);
    chk("rst_done1", 128'(done1), 128'd0);
    chk("rst_dout1", dout1, 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // known-answer table
    for (int i = 0; i < 3; i++) begin
      drive(vt[i].lki, vt[i].key, vt[i].din, vt[i].pt, 1'b1);
      wait_done(vt[i].lki, 0, '0, lat, bcnt);
      chk("kat_latency", 128'(lat), 128'(vt[i].lat));
      chk("kat_busy_cycles", 128'(bcnt), 128'(vt[i].busy));
      @(posedge clk);
      #1;
      chk("kat_done_pulse", 128'(vt[i].lki ? done1 : done0), 128'd0);
    end

    // START while busy is ignored; START in the DONE cycle is accepted
    drive(1'b0, vt[0].key, vt[0].din, vt[0].pt, 1'b1);
    wait_done(1'b0, 5, vt[1].din, lat, bcnt);
    chk("ignore_latency", 128'(lat), 128'd21);
    drive(1'b0, vt[1].key, vt[1].din, vt[1].pt, 1'b1);
    wait_done(1'b0, 0, '0, lat, bcnt);
    chk("b2b_latency", 128'(lat), 128'd21);

    // reset mid-block aborts it without a DONE
    @(posedge clk);
    #1;
    drive(1'b0, vt[0].key, vt[0].din, '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
    end
    chk("abort_busy_before", 128'(busy0), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_done", 128'(done0), 128'd0);
    chk("abort_busy", 128'(busy0), 128'd0);
    chk("abort_dout", dout0, 128'd0);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done0 || busy0) dcnt++;
    end
    chk("abort_quiet", 128'(dcnt), 128'd0);
    drive(1'b0, vt[1].key, vt[1].din, vt[1].pt, 1'b1);
    wait_done(1'b0, 0, '0, lat, bcnt);
    chk("after_abort_latency", 128'(lat), 128'd21);

    // loopback against the encryption model
    for (int i = 0; i < 100; i++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
      drive(1'b0, k, m_enc(k, p), p, 1'b1);
      wait_done(1'b0, 0, '0, lat, bcnt);
      chk("loop_latency", 128'(lat), 128'd21);
    end
    for (int i = 0; i < 8; i++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
      drive(1'b1, m_key10(k), m_enc(k, p), p, 1'b1);
      wait_done(1'b1, 0, '0, lat, bcnt);
      chk("loop_lk_latency", 128'(lat), 128'd11);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb0_drained", 128'(q0.size()), 128'd0);
    chk("sb1_drained", 128'(q1.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_dec_iter.md
Name: aes128_dec_iter

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher): one round per clock, with an on-the-fly inverse key schedule and no round-key storage.
- Receive-side counterpart of the team's AES-128 encryption datapath; consumes its 128-bit ciphertext blocks and returns plaintext.
- Single block in flight; START/DONE pulse handshake with a BUSY indication.

Parameters:
- LAST_KEY_IN, 0, 0: KEY is the cipher key and the core runs the forward expansion to round key 10 first. 1: KEY is already round key 10, and KEXP is skipped.

Ports:
- CLK  input  1  clock, all state on rising edge
- RST  input  1  synchronous, active-high reset
- START  input  1  one-cycle request; sampled only in IDLE
- DIN  input  128  ciphertext, byte 0 = DIN[127:120]; sampled with START
- KEY  input  128  cipher key, or round-10 key when LAST_KEY_IN=1; sampled with START
- BUSY  output  1  high from the cycle after START acceptance until DONE is asserted
- DONE  output  1  one-cycle pulse; DOUT valid
- DOUT  output  128  plaintext; holds its value until the next accepted START

Behaviour:
- Reset: state=IDLE, DONE=0, BUSY=0, DOUT=0, rnd=0, internal state/key registers = 0.
- RST mid-operation aborts the block; no DONE is produced for it.
- IDLE:
  - START=1 latches DIN into ct_q and KEY into key_q, and sets BUSY=1.
  - LAST_KEY_IN=0: go to KEXP with rnd=1.
  - LAST_KEY_IN=1: go to ROUND with st_q=DIN^KEY and rnd=9.
- START outside IDLE is ignored; there is no queueing.
- KEXP (10 cycles, rnd 1..10), forward schedule:
  - key_q <= next(key_q, Rcon[rnd]) with w0'=w0^SubWord(RotWord(w3))^Rcon, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 (in the MSB of the word).
  - On rnd=10: st_q <= ct_q ^ next_key, key_q <= next_key (round key 10), rnd <= 9, go to ROUND.
- ROUND (10 cycles, rnd 9 down to 0):
  - Previous key is formed combinationally from key_q (round r+1) using Rcon[r+1]:
    - w3p=w3^w2, w2p=w2^w1, w1p=w1^w0.
    - w0p=w0^SubWord(RotWord(w3p))^Rcon[r+1].
  - rk_r = {w0p,w1p,w2p,w3p}.
  - t = InvSubBytes(InvShiftRows(st_q)) ^ rk_r.
  - rnd>0: st_q <= InvMixColumns(t), key_q <= rk_r, rnd <= rnd-1.
  - rnd=0: DOUT <= t, DONE <= 1, BUSY <= 0, go to IDLE.
- Latency from the START sampling edge to the DONE-high cycle: 21 clocks (LAST_KEY_IN=0), 11 clocks (LAST_KEY_IN=1).
- A new START is accepted in the same cycle DONE is high (state is IDLE then), which allows back-to-back blocks.
- All arithmetic is GF(2^8) with polynomial 0x11b. InvMixColumns coefficients: 0e,0b,0d,09.
- Round counter is 4-bit and never wraps. Any rnd value outside 1..10 in KEXP or outside 0..9 in ROUND forces IDLE (defensive).

Decomposition:
- Shared include aes128_dec_func.v holds:
  - functions sbox, inv_sbox, xtime, gmul (by 09/0b/0d/0e), inv_mix_col (32-bit), rcon(4-bit index).
  - state encodings IDLE/KEXP/ROUND as localparams.
- One natural sub-module: aes128_inv_round, purely combinational.
  - Inputs: st, key, rnd.
  - Outputs: next_st, prev_key, and final-round t.

Test Plan:
- LAST_KEY_IN=0, KEY=000102030405060708090a0b0c0d0e0f, DIN=69c4e0d86a7b0430d8cdb78070b4c55a -> DONE 21 clocks after START, DOUT=00112233445566778899aabbccddeeff, BUSY high for exactly 20 cycles.
- LAST_KEY_IN=0, KEY=2b7e151628aed2a6abf7158809cf4f3c, DIN=3925841d02dc09fbdc118597196a0b32 -> DOUT=3243f6a8885a308d313198a2e0370734; DONE is a single-cycle pulse.
- LAST_KEY_IN=1, KEY=13111d7fe3944a17f307a78b4d2b30c5, DIN=69c4e0d86a7b0430d8cdb78070b4c55a -> DONE after 11 clocks, DOUT=00112233445566778899aabbccddeeff.
- START pulsed again at cycle 5 with different DIN -> ignored; result equals the first block's plaintext. Then START in the DONE cycle -> second block accepted and completes 21 clocks later.
- RST asserted at cycle 12 of a block -> next cycle DONE=0, BUSY=0, DOUT=0. No DONE until a new START, which then decrypts correctly.
- Loopback with the encryption core: 100 random key/plaintext pairs -> decrypted DOUT equals the original plaintext for every pair.
